// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, writes the IF/ID latch, halts on HALT opcode.
// Latency: imem word to IF/ID outputs is combinational; redirect_pc reaches imem_addr one cycle later.
// Backpressure: stall holds PC and counters and drops ifid_wen; a memory wait writes one NOP bubble per cycle.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic [15:0] instr,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        halted,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_pc_plus2;
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_bubble_cnt;
    logic        w_fetch_inc;
    logic        w_bubble_inc;
    logic        w_wen;
    logic        w_flush;
    logic [15:0] w_instr;
    logic [15:0] w_npc;

    assign w_pc_plus2 = r_pc + 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC;
            r_fetch_cnt  <= 16'h0000;
            r_bubble_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_fetch_inc) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_bubble_inc) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    // Priority: redirect, stall, then RUN fetch/wait, else HALTED bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_wen        = 1'b0;
        w_flush      = 1'b0;
        w_instr      = NOP_INSTR;
        w_npc        = r_pc;
        w_fetch_inc  = 1'b0;
        w_bubble_inc = 1'b0;
        if (redirect) begin
            w_state_nxt = RUN;
            w_pc_nxt    = redirect_pc;
            w_wen       = 1'b1;
            w_flush     = 1'b1;
            w_npc       = redirect_pc;
        end else if (stall) begin
            w_wen = 1'b0;
        end else if (r_state == RUN) begin
            w_wen = 1'b1;
            if (imem_valid) begin
                w_instr     = imem_rdata;
                w_npc       = w_pc_plus2;
                w_fetch_inc = 1'b1;
                // The HALT word itself still goes to IF/ID; only the PC stops.
                if (imem_rdata[15:12] == HALT_OPCODE) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_pc_nxt = w_pc_plus2;
                end
            end else begin
                w_bubble_inc = 1'b1;
            end
        end else begin
            w_wen = 1'b1;
        end
    end

    assign imem_addr  = r_pc;
    assign imem_req   = (r_state == RUN);
    assign pc         = r_pc;
    assign npc        = w_npc;
    assign instr      = w_instr;
    assign ifid_wen   = w_wen;
    assign ifid_flush = w_flush;
    assign halted     = (r_state == HALTED);
    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table through an expectation queue, plus reset corner sequences.
// Inputs change on the falling edge and outputs are sampled 2 time units later.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] instr;
    logic        ifid_wen;
    logic        ifid_flush;
    logic        halted;
    logic [15:0] fetch_cnt;
    logic [15:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .HALT_OPCODE(4'hF),
        .NOP_INSTR  (16'h4000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .npc        (npc),
        .instr      (instr),
        .ifid_wen   (ifid_wen),
        .ifid_flush (ifid_flush),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [15:0] rdata;
        logic        stl;
        logic        rdr;
        logic [15:0] rpc;
        logic [15:0] e_pc;
        logic        e_req;
        logic        e_wen;
        logic        e_flush;
        logic        e_halt;
        logic        chk_data;
        logic [15:0] e_instr;
        logic [15:0] e_npc;
        logic [15:0] e_fc;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [15:0] rd, input logic st, input logic rr,
                       input logic [15:0] rp, input logic [15:0] p, input logic rq, input logic we,
                       input logic fl, input logic hl, input logic cd, input logic [15:0] ins,
                       input logic [15:0] np, input logic [15:0] fc, input logic [15:0] bc);
        vec_t t;
        t = '{v, rd, st, rr, rp, p, rq, we, fl, hl, cd, ins, np, fc, bc};
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        imem_valid  = t.vld;
        imem_rdata  = t.rdata;
        stall       = t.stl;
        redirect    = t.rdr;
        redirect_pc = t.rpc;
        exp_q.push_back(t);
    endtask

    task automatic check_out(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 16'd1, 16'd0);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("v%0d pc", idx), pc, e.e_pc);
        chk($sformatf("v%0d imem_addr", idx), imem_addr, e.e_pc);
        chk($sformatf("v%0d imem_req", idx), {15'd0, imem_req}, {15'd0, e.e_req});
        chk($sformatf("v%0d ifid_wen", idx), {15'd0, ifid_wen}, {15'd0, e.e_wen});
        chk($sformatf("v%0d ifid_flush", idx), {15'd0, ifid_flush}, {15'd0, e.e_flush});
        chk($sformatf("v%0d halted", idx), {15'd0, halted}, {15'd0, e.e_halt});
        chk($sformatf("v%0d fetch_cnt", idx), fetch_cnt, e.e_fc);
        chk($sformatf("v%0d bubble_cnt", idx), bubble_cnt, e.e_bc);
        if (e.chk_data) begin
            chk($sformatf("v%0d instr", idx), instr, e.e_instr);
            chk($sformatf("v%0d npc", idx), npc, e.e_npc);
        end
    endtask

    initial begin
        // Sequential fetch from 0
        add(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0002, 16'd0, 16'd0);
        add(1'b1, 16'h1001, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1001, 16'h0004, 16'd1, 16'd0);
        add(1'b1, 16'h1002, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1002, 16'h0006, 16'd2, 16'd0);
        add(1'b1, 16'h1003, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1003, 16'h0008, 16'd3, 16'd0);
        // Redirect back to 4 with a valid word present: squashed
        add(1'b1, 16'h1004, 1'b0, 1'b1, 16'h0004, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h0004, 16'd4, 16'd0);
        // Three wait cycles at pc=4
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0004, 16'd4, 16'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0004, 16'd4, 16'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0004, 16'd4, 16'd2);
        add(1'b1, 16'h1004, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1004, 16'h0006, 16'd4, 16'd3);
        add(1'b1, 16'h1006, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1006, 16'h0008, 16'd5, 16'd3);
        // Stall over a valid word at pc=8, then delivery
        add(1'b1, 16'h1008, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd6, 16'd3);
        add(1'b1, 16'h1008, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd6, 16'd3);
        add(1'b1, 16'h1008, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1008, 16'h000A, 16'd6, 16'd3);
        // Redirect + stall + valid HALT word: redirect wins, HALT squashed
        add(1'b1, 16'hF000, 1'b1, 1'b1, 16'h0040, 16'h000A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h0040, 16'd7, 16'd3);
        add(1'b1, 16'h1040, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1040, 16'h0042, 16'd7, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0042, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h0010, 16'd8, 16'd3);
        // HALT at 0x10, halted cycles, restart by redirect to 0x20
        add(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF000, 16'h0012, 16'd8, 16'd3);
        add(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 16'h0010, 16'd9, 16'd3);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'd9, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0020, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h0020, 16'd9, 16'd3);
        add(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0022, 16'd9, 16'd3);
        // Wrap at 0xFFFE
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 16'h0022, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'hFFFE, 16'd10, 16'd3);
        add(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'd10, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, 16'd11, 16'd3);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, 16'h0030, 16'd11, 16'd4);

        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 16'h0000;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #2;
        chk("rst pc", pc, 16'h0000);
        chk("rst imem_req", {15'd0, imem_req}, 16'd1);
        chk("rst halted", {15'd0, halted}, 16'd0);
        chk("rst ifid_flush", {15'd0, ifid_flush}, 16'd0);
        chk("rst ifid_wen", {15'd0, ifid_wen}, 16'd1);
        chk("rst instr", instr, 16'h4000);
        chk("rst fetch_cnt", fetch_cnt, 16'd0);
        chk("rst bubble_cnt", bubble_cnt, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check_out(i);
            @(negedge clk);
        end

        // Asynchronous reset between edges
        imem_valid = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        #1;
        chk("pre_rst pc", pc, 16'h0030);
        chk("pre_rst bubble_cnt", bubble_cnt, 16'd4);
        rst_n = 1'b0;
        #1;
        chk("async_rst pc", pc, 16'h0000);
        chk("async_rst fetch_cnt", fetch_cnt, 16'd0);
        chk("async_rst bubble_cnt", bubble_cnt, 16'd0);

        // Halt, then reset mid-halt with stall asserted
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hF000;
        #2;
        chk("halt_word instr", instr, 16'hF000);
        chk("halt_word halted", {15'd0, halted}, 16'd0);
        @(negedge clk);
        imem_valid = 1'b0;
        #1;
        chk("halted halted", {15'd0, halted}, 16'd1);
        chk("halted imem_req", {15'd0, imem_req}, 16'd0);
        chk("halted pc", pc, 16'h0000);
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_in_halt halted", {15'd0, halted}, 16'd0);
        chk("rst_in_halt imem_req", {15'd0, imem_req}, 16'd1);
        chk("rst_in_halt fetch_cnt", fetch_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the PC and writes the IF/ID pipeline latch. Each cycle it drives the instruction-memory address and accepts the returned word. It then presents `npc`, `instr` and the write/flush controls to the IF/ID latch. It honours hazard stalls and branch redirects from decode, stops on a HALT opcode, and keeps fetch/bubble performance counters.

## Interface

Parameters:

- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `HALT_OPCODE`, 4'hF: value of `instr[15:12]` that halts fetch.
- `NOP_INSTR`, 16'h4000: encoding written to IF/ID for bubbles and flushes.

Ports:

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  16: fetch address; always equals `pc`.
- `imem_req`  out  1: fetch request.
- `imem_rdata`  in  16: instruction word.
- `imem_valid`  in  1: `imem_rdata` is valid for the current `imem_addr` this cycle.
- `stall`  in  1: hazard unit requests that PC and IF/ID hold.
- `redirect`  in  1: taken branch/jump resolved in decode.
- `redirect_pc`  in  16: redirect target.
- `pc`  out  16: current PC register.
- `npc`  out  16: next-PC value for the IF/ID latch.
- `instr`  out  16: instruction for the IF/ID latch.
- `ifid_wen`  out  1: IF/ID write enable.
- `ifid_flush`  out  1: marks that `instr` is a squash bubble.
- `halted`  out  1: fetch has stopped on HALT.
- `fetch_cnt`  out  16: count of real instructions written to IF/ID.
- `bubble_cnt`  out  16: count of NOP bubbles written because of memory wait.

## Operation

- **FSM states:** `RUN` and `HALTED`.
- **Request and output timing:** `imem_req = (state == RUN)`. `imem_addr = pc`. All other outputs are combinational from `state`, `pc` and the inputs, decided each cycle in this priority order.
- **Priority 1, `redirect` (any state):**
  - `pc` <= `redirect_pc`; `state` <= `RUN`.
  - `ifid_wen=1`, `ifid_flush=1`, `instr=NOP_INSTR`, `npc=redirect_pc`.
  - `imem_valid`/`imem_rdata` are ignored. `stall` is ignored. No counter changes.
- **Priority 2, `stall`:** `ifid_wen=0`, `pc` held, `imem_req` unchanged, counters held.
- **Priority 3, `RUN` and `imem_valid`:**
  - `instr=imem_rdata`, `npc=pc+2` (16-bit, wraps 16'hFFFE -> 16'h0000).
  - `ifid_wen=1`, `ifid_flush=0`, `fetch_cnt` += 1.
  - If `imem_rdata[15:12]==HALT_OPCODE`: the HALT word is still written to IF/ID, `pc` holds, and `state` <= `HALTED`.
  - Otherwise `pc` <= `pc+2`.
- **Priority 4, `RUN` and not `imem_valid`:** `instr=NOP_INSTR`, `npc=pc`, `ifid_wen=1`, `ifid_flush=0`, `pc` held, `bubble_cnt` += 1.
- **`HALTED` without `redirect`:** `ifid_wen=1` with `NOP_INSTR`, `npc=pc`, `imem_req=0`, `halted=1`, `pc` and counters held.
- **Counters:** 16-bit and wrap silently.

## Timing

- **Reset (`rst_n` low, asynchronous):**
  - Registers: `pc=RESET_PC`, `state=RUN`, `fetch_cnt=0`, `bubble_cnt=0`.
  - Outputs during reset: `imem_req=1`, `halted=0`, `ifid_flush=0`. `ifid_wen`, `instr` and `npc` follow the rules above from the reset register values.
  - Reset asserted mid-stall or mid-halt returns to `RUN` immediately.
- **Deassertion:** first fetch occurs on the first rising edge after `rst_n` goes high.
- **Latency:**
  - Memory word to IF/ID outputs: 0 cycles (combinational). The latch captures it on the same edge that advances `pc`.
  - `redirect_pc` to `imem_addr`: 1 cycle.
- **Multi-cycle memory:** `imem_addr` is stable while `imem_valid=0`. Each wait cycle inserts exactly one bubble.
- **Simultaneous events:**
  - `redirect` + `stall`: redirect wins.
  - `redirect` + HALT word valid: HALT is squashed and `halted` stays 0.
  - `stall` + `imem_valid`: the word is dropped and refetched later from the same `pc`.
- **Halt visibility:** `halted` rises in the cycle after the HALT word is written to IF/ID.

## Test plan

- **Reset and sequential fetch:** `RESET_PC=0`, memory always valid with non-HALT words, run 4 cycles.
  - -> `imem_addr` 0,2,4,6; `npc` 2,4,6,8; `fetch_cnt=4`; `bubble_cnt=0`.
- **Memory wait:** at `pc=4`, hold `imem_valid=0` for 3 cycles.
  - -> 3 cycles of `instr=16'h4000` with `ifid_wen=1`; `pc` stays 4; `bubble_cnt=3`.
  - -> on the next valid cycle, `npc=6`.
- **Stall over valid:** at `pc=8`, assert `stall` for 2 cycles.
  - -> `ifid_wen=0`, `pc=8`, counters unchanged.
  - -> after release, the word at 8 is delivered with `npc=10`.
- **Redirect:** `redirect=1`, `redirect_pc=16'h0040`, with `stall=1` and `imem_valid=1` in the same cycle.
  - -> `ifid_flush=1`, `instr=NOP`.
  - -> next cycle `imem_addr=16'h0040`, `fetch_cnt` unchanged.
- **Halt and restart:** fetch `16'hF000` at `pc=16'h0010`.
  - -> HALT written to IF/ID.
  - -> next cycle `halted=1`, `imem_req=0`, `pc=16'h0010`.
  - -> a later `redirect` to `16'h0020` returns to `RUN`.
- **Wrap and async reset:** start at `pc=16'hFFFE` with a valid word.
  - -> `npc=0` and `pc` becomes 0.
  - -> pulse `rst_n` low between clock edges: `pc=RESET_PC` immediately, both counters 0.
